uart_receiver_fsm: RTL and testbench
====================================

# uart_receiver_fsm

UART receive engine: recovers 8-bit frames (start, 8 data LSB-first, optional parity, 1 stop) from a serial line using 16x oversampling. It converts serial to parallel for the same links driven by the team's UART transmitter and hands each byte to the local logic with a one-cycle valid strobe. There is no backpressure; the consumer must take `dout` when `valid` is high.

## Interface
- `CLK_FREQ`, 50000000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit. The block supports only 16.
- `DIV`, CLK_FREQ/(BAUD*OVERSAMPLE): clocks per tick. It is derived and must be ≥ 2. The default is 325.
- `PARITY_ODD`, 0: with `UART_RX_PARITY_EN` defined, 0 selects even parity and 1 selects odd.

Ports:
- `clk`  in  1  system clock; all logic runs on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial input; idle level is 1.
- `dout`  out  8  last received data byte.
- `valid`  out  1  one-cycle pulse when a good frame completes.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled as 0.
- `parity_err`  out  1  one-cycle pulse on parity mismatch. It is tied to 0 when parity is compiled out.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- The tick generator pulses `tick` for one clock every `DIV` clocks. It runs freely and is not re-phased on a start edge.
- A 4-bit sample counter `scnt` advances on `tick`. A 3-bit `bit_cnt` counts data bits. An 8-bit shift register fills from the MSB end, shifting right, so bit 0 is received first.

State machine:
- **IDLE**
  - On a tick with `rx_s`=0: clear `scnt` and go to START.
- **START**
  - On the tick where `scnt`=7 (mid start bit): if `rx_s`=0, clear `scnt` and `bit_cnt` and go to DATA. Otherwise the start is false; go to IDLE with no strobe.
- **DATA**
  - On the tick where `scnt`=15 (mid bit), shift `rx_s` in.
  - If `bit_cnt`=7, go to PARITY (when enabled) or STOP. Otherwise increment `bit_cnt`.
- **PARITY**
  - On the tick where `scnt`=15, capture the parity bit and go to STOP.
- **STOP**
  - On the tick where `scnt`=15 (mid stop bit), copy the shift register to `dout`.
  - If `rx_s`=1 and parity is OK: pulse `valid` and go to IDLE.
  - If `rx_s`=1 and parity is bad: pulse `parity_err` and go to IDLE.
  - If `rx_s`=0: pulse `frame_err`, regardless of parity, and go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until a tick with `rx_s`=1, then go to IDLE. This stops a break condition from being decoded as repeated 0x00 frames.

Strobes:
- `valid`, `frame_err` and `parity_err` are mutually exclusive.
- `dout` holds its value until the next frame reaches the stop sample. It changes on every completed frame, good or bad.

## Timing
- Reset values:
  - `dout`=0x00, `valid`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - State=IDLE, `scnt`=0, `bit_cnt`=0, shift register=0.
- Reset applies mid-frame: the block returns to IDLE on the next edge and no strobe is produced for the aborted frame.
- Synchronizer latency is 2 clocks. Start detection adds up to 1 tick of uncertainty, so the sample point lands at mid-bit ±1 tick.
- `valid` rises 1 clock after the stop-bit sample tick, about 9.5 bit times after the falling start edge, and stays high for exactly 1 clock.
- Back-to-back frames are supported. The block returns to IDLE at mid-stop, so a start edge anywhere in the second half of the stop bit is caught.
- A low pulse on `rx` shorter than 8 ticks is rejected as a false start.

## Configuration
- `UART_RX_PARITY_EN`:
  - Defined: the PARITY state exists, the frame is 11 bits, and `parity_err` is live. Parity sense follows `PARITY_ODD`.
  - Undefined: no PARITY state, the frame is 10 bits, `parity_err` is tied to 0, and `PARITY_ODD` is ignored.

## Structure
- Package `uart_pkg`, shared with the transmitter, holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the `OVERSAMPLE` constant;
  - the mid-bit sample index constants 7 and 15.
- Sub-module `uart_baud_tick(CLK_FREQ, BAUD, OVERSAMPLE)` produces `tick`. The counter width is $clog2(DIV).

## Test plan
All scenarios use `CLK_FREQ`=1600000 and `BAUD`=10000, giving `DIV`=10 and 160 clocks per bit.
- **Single frame:** send 0xA5 with stop=1 → exactly one `valid` pulse, `dout`=0xA5, `busy` low after the stop sample.
- **False start:** hold `rx` low for 50 clocks, then high → no strobe; `busy` returns to 0 within 8 ticks.
- **Framing error:** send 0x3C with stop=0, hold `rx` low for 3 bit times, release, then send 0x5A → `frame_err` pulses once with `dout`=0x3C, no spurious 0x00 frames, then `valid` with `dout`=0x5A.
- **Back-to-back:** send 0x00, 0xFF, 0x81 with no idle gap → three `valid` pulses, in order, with the correct `dout` at each.
- **Reset mid-frame:** assert `rst` for 1 clock during data bit 4 of 0x77, then send 0x12 → no strobe for the aborted frame, all outputs at reset values, then `valid` with `dout`=0x12.
- **Parity** (with `UART_RX_PARITY_EN` defined, `PARITY_ODD`=0): send 0x03 with parity bit 0 → `valid`; send 0x03 with parity bit 1 → `parity_err` only.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and oversampling constants.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StWaitHigh
  } uart_state_e;

  localparam int unsigned Oversample = 16;

  // Sample indices: mid start bit after detection, and mid bit for all later bits.
  localparam logic [3:0] SampleMidStart = 4'd7;
  localparam logic [3:0] SampleMidBit   = 4'd15;

endpackage

// File: rtl/uart_receiver_fsm_if.sv
// Serial-in / parallel-out bundle for the UART receive engine.
interface uart_receiver_fsm_if;

  logic       rx;
  logic [7:0] dout;
  logic       valid;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  // master drives the line and consumes bytes; slave is the receiver
  modport master (
    output rx,
    input  dout,
    input  valid,
    input  frame_err,
    input  parity_err,
    input  busy
  );

  modport slave (
    input  rx,
    output dout,
    output valid,
    output frame_err,
    output parity_err,
    output busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-clock pulse every CLK_FREQ/(BAUD*OVERSAMPLE) clocks.
module uart_baud_tick #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst,
  output logic o_tick
);

  localparam int unsigned DIV  = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_cnt == CntMax) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

  assign o_tick = (r_cnt == CntMax);

endmodule

// File: rtl/uart_receiver_fsm.sv
// UART receive engine, 16x oversampled, 8 data bits LSB first, 1 stop bit.
// Optional parity bit when UART_RX_PARITY_EN is defined (sense selected by PARITY_ODD).
module uart_receiver_fsm
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = Oversample,
  parameter bit          PARITY_ODD = 1'b0
) (
  input logic               clk,
  input logic               rst,
  uart_receiver_fsm_if.slave bus
);

  logic        w_tick;
  logic        w_par_bad;

  logic        r_rx_meta;
  logic        r_rx_s;
  uart_state_e r_state;
  logic [3:0]  r_scnt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic [7:0]  r_dout;
  logic        r_valid;
  logic        r_frame_err;
  logic        r_parity_err;

  uart_baud_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_tick (
    .clk   (clk),
    .rst   (rst),
    .o_tick(w_tick)
  );

  // Synchronizer resets to the idle line level so reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  assign w_par_bad = r_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_scnt       <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
`endif
    end else begin
      r_valid      <= 1'b0;
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
      if (w_tick) begin
        unique case (r_state)
          StIdle: begin
            if (!r_rx_s) begin
              r_scnt  <= '0;
              r_state <= StStart;
            end
          end
          StStart: begin
            if (r_scnt == SampleMidStart) begin
              if (!r_rx_s) begin
                r_scnt    <= '0;
                r_bit_cnt <= '0;
                r_state   <= StData;
              end else begin
                r_state <= StIdle;
              end
            end else begin
              r_scnt <= r_scnt + 4'd1;
            end
          end
          // scnt wraps 15 -> 0, so each later bit is sampled 16 ticks after the previous one
          StData: begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == SampleMidBit) begin
              r_shift <= {r_rx_s, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                r_state <= StParity;
`else
                r_state <= StStop;
`endif
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end
          end
`ifdef UART_RX_PARITY_EN
          StParity: begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == SampleMidBit) begin
              r_par_bad <= ((^r_shift) ^ r_rx_s) != PARITY_ODD;
              r_state   <= StStop;
            end
          end
`endif
          StStop: begin
            r_scnt <= r_scnt + 4'd1;
            if (r_scnt == SampleMidBit) begin
              r_dout <= r_shift;
              if (!r_rx_s) begin
                r_frame_err <= 1'b1;
                r_state     <= StWaitHigh;
              end else begin
                r_parity_err <= w_par_bad;
                r_valid      <= !w_par_bad;
                r_state      <= StIdle;
              end
            end
          end
          // Hold off on a break so a stuck-low line is not decoded as 0x00 frames.
          StWaitHigh: begin
            if (r_rx_s) begin
              r_state <= StIdle;
            end
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign bus.dout       = r_dout;
  assign bus.valid      = r_valid;
  assign bus.frame_err  = r_frame_err;
  assign bus.parity_err = r_parity_err;
  assign bus.busy       = (r_state != StIdle);

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Bench for uart_receiver_fsm: directed scenarios plus random frames against a frame-level model.
module tb_uart_receiver_fsm;

  localparam int unsigned ClkFreq   = 1600000;
  localparam int unsigned Baud      = 10000;
  localparam int unsigned BitClks   = 160;
  localparam bit          ParityOdd = 1'b0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_receiver_fsm_if bus ();

  uart_receiver_fsm #(
    .CLK_FREQ  (ClkFreq),
    .BAUD      (Baud),
    .OVERSAMPLE(16),
    .PARITY_ODD(ParityOdd)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Strobe kinds as {parity_err, frame_err, valid}
  localparam logic [2:0] KValid  = 3'b001;
  localparam logic [2:0] KFrame  = 3'b010;
  localparam logic [2:0] KParity = 3'b100;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_byte = 8'h00;
  int         n_checks  = 0;
  int         n_errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_bit(input logic v);
    bus.rx = v;
    repeat (BitClks) @(negedge clk);
  endtask

  // Model: a frame yields exactly one strobe; a low stop bit wins over parity.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic par_flip);
    exp_t e;
    logic p;
    p = (^b) ^ ParityOdd ^ par_flip;
    if (!stop) e.kind = KFrame;
    else if (par_flip) e.kind = KParity;
    else e.kind = KValid;
    e.data = b;
    exp_q.push_back(e);
    last_byte = b;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(p);
`else
    if (p) begin end
`endif
    drive_bit(stop);
  endtask

  task automatic scenario_end(input string tag, input int idle_bits);
    bus.rx = 1'b1;
    repeat (idle_bits * BitClks) @(negedge clk);
    check_eq({tag, "_pending"}, 32'(exp_q.size()), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
    check_eq({tag, "_dout_hold"}, 32'(bus.dout), 32'(last_byte));
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_dout"}, 32'(bus.dout), 0);
    check_eq({tag, "_valid"}, 32'(bus.valid), 0);
    check_eq({tag, "_frame_err"}, 32'(bus.frame_err), 0);
    check_eq({tag, "_parity_err"}, 32'(bus.parity_err), 0);
    check_eq({tag, "_busy"}, 32'(bus.busy), 0);
  endtask

  // Every strobe must match the oldest outstanding frame; width >1 clock shows up as spurious.
  always @(negedge clk) begin
    logic [2:0] got;
    exp_t       e;
    if (!rst && (bus.valid || bus.frame_err || bus.parity_err)) begin
      got = {bus.parity_err, bus.frame_err, bus.valid};
      if (exp_q.size() == 0) begin
        check_eq("spurious_strobe", 32'(got), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("strobe_kind", 32'(got), 32'(e.kind));
        check_eq("strobe_dout", 32'(bus.dout), 32'(e.data));
      end
    end
  end

  initial begin
    logic [7:0] b;
    logic       stop;
    logic       flip;

    bus.rx = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;
    repeat (2 * BitClks) @(negedge clk);

    send_frame(8'hA5, 1'b1, 1'b0);
    scenario_end("single", 1);

    // False start: 50 clocks low is 5 ticks, below the 8-tick qualification.
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("false_start_busy_hi", 32'(bus.busy), 1);
    repeat (10) @(negedge clk);
    bus.rx = 1'b1;
    repeat (80) @(negedge clk);
    check_eq("false_start_busy_lo", 32'(bus.busy), 0);
    scenario_end("false_start", 1);

    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (3 * BitClks) @(negedge clk);
    check_eq("break_busy", 32'(bus.busy), 1);
    check_eq("break_pending", 32'(exp_q.size()), 0);
    bus.rx = 1'b1;
    repeat (2 * BitClks) @(negedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    scenario_end("frame_err", 1);

    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0);
    scenario_end("b2b", 1);

    // Abort 0x77 halfway through data bit 4.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & ((8'h77 >> i) & 8'h01) != 0);
    bus.rx = 1'b1;
    repeat (BitClks / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_values("mid_reset");
    last_byte = 8'h00;
    scenario_end("mid_reset_idle", 2);
    send_frame(8'h12, 1'b1, 1'b0);
    scenario_end("after_reset", 1);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b0);
    scenario_end("parity_ok", 1);
    send_frame(8'h03, 1'b1, 1'b1);
    scenario_end("parity_bad", 1);
`endif

    for (int n = 0; n < 24; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      flip = 1'b0;
`ifdef UART_RX_PARITY_EN
      flip = ($urandom_range(0, 3) == 0);
`endif
      send_frame(b, stop, flip);
      bus.rx = 1'b1;
      if (!stop) repeat (BitClks) @(negedge clk);
      repeat ($urandom_range(0, 2) * BitClks + $urandom_range(0, 30)) @(negedge clk);
    end
    scenario_end("random", 2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #50ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
